// File: rtl/dffnq_seq_pkg.sv
// dffnq_seq_pkg: shared state encoding and counter sizing for the shift sequencer.
package dffnq_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_e;

   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/dffnq_shift_chain.sv
// dffnq_shift_chain: WIDTH-bit falling-edge chain with parallel load and LSB-out shift.
module dffnq_shift_chain #(
   parameter int WIDTH = 8
) (
   input  logic             CLKN,
   input  logic             RST,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic             sin_i,
   input  logic [WIDTH-1:0] pdin_i,
   output logic [WIDTH-1:0] chain_d_o,
   output logic             sout_o
);
   logic [WIDTH-1:0] chain_q, chain_d;

   always_comb chain_d = load_i ? pdin_i : shift_i ? {sin_i, chain_q[WIDTH-1:1]} : chain_q;

   always_ff @(negedge CLKN) chain_q <= RST ? '0 : chain_d;

   assign chain_d_o = chain_d;
   assign sout_o    = chain_q[0];
endmodule

// File: rtl/dffnq_shift_sequencer.sv
// dffnq_shift_sequencer: loads a falling-edge chain, streams it out under valid/ready,
// and captures the WIDTH shifted-in SIN bits on PDOUT with a one-cycle DONE.
module dffnq_shift_sequencer
   import dffnq_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLKN,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] PDIN,
   input  logic             SIN,
   output logic             SOUT,
   output logic             SOUT_VALID,
   input  logic             SOUT_READY,
   output logic [WIDTH-1:0] PDOUT,
   output logic             DONE,
   output logic             BUSY
);
   localparam int CNT_W = cnt_w(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [WIDTH-1:0] pdout_q, pdout_d, chain_d;
   logic             load, xfer, last;

   dffnq_shift_chain #(.WIDTH(WIDTH)) u_chain (
      .CLKN      (CLKN),
      .RST       (RST),
      .load_i    (load),
      .shift_i   (xfer),
      .sin_i     (SIN),
      .pdin_i    (PDIN),
      .chain_d_o (chain_d),
      .sout_o    (SOUT)
   );

   // PDOUT captures the chain's next value so the final SIN bit is included at FIN entry.
   always_comb begin
      load    = (state_q == IDLE) && START;
      xfer    = (state_q == SHIFT) && SOUT_READY;
      last    = xfer && (count_q == CNT_W'(WIDTH - 1));
      count_d = load ? '0 : xfer ? count_q + CNT_W'(1) : count_q;
      pdout_d = last ? chain_d : pdout_q;
      state_d = load ? SHIFT : last ? FIN : (state_q == SHIFT) ? SHIFT : IDLE;
   end

   always_ff @(negedge CLKN) begin
      if (RST) begin
         state_q <= IDLE;
         count_q <= '0;
         pdout_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pdout_q <= pdout_d;
      end
   end

   assign SOUT_VALID = (state_q == SHIFT);
   assign DONE       = (state_q == FIN);
   assign BUSY       = (state_q != IDLE);
   assign PDOUT      = pdout_q;
endmodule
